store_buffer: RTL
=================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, number of pending-store entries (power of two, 2..16).
REQ-002 The block SHALL have the following ports, one per line:
  clk_i           in   1   clock, all state updates on rising edge
  rst_i           in   1   reset, synchronous, active-low
  mem_write_i     in   1   CPU store request
  mem_read_i      in   1   CPU load request
  addr_i          in   32  CPU byte address (word-aligned)
  data_i          in   32  CPU store data
  stall_o         out  1   store not accepted this cycle; CPU holds request
  data_o          out  32  load result
  data_valid_o    out  1   one-cycle pulse, data_o updated
  empty_o         out  1   no pending stores (fence/halt use)
  dm_addr_o       out  32  data-memory address
  dm_data_o       out  32  data-memory write data
  dm_mem_write_o  out  1   data-memory write enable
  dm_mem_read_o   out  1   data-memory read enable
  dm_data_i       in   32  data-memory read data, valid the cycle after dm_mem_read_o
REQ-003 One clock (clk_i); reset rst_i is synchronous and active-low.

Function
REQ-004 Buffer SHALL be a circular FIFO of DEPTH entries {addr[31:0], data[31:0]}, head/tail pointers wrapping modulo DEPTH, count 0..DEPTH.
REQ-005 Store accept: mem_write_i=1 and count<DEPTH -> entry enqueued at tail at the clock edge; stall_o=0.
REQ-006 Store when full: mem_write_i=1 and count=DEPTH -> stall_o=1 (combinational), no enqueue; head is drained the same cycle; store is accepted the following cycle (exactly one stall cycle).
REQ-007 Drain: memory port is idle (mem_write_i=0, mem_read_i=0) and count>0, or the REQ-006 case -> dm_mem_write_o=1, dm_addr_o/dm_data_o = head entry, head pops at the edge; otherwise dm_mem_write_o=0.
REQ-008 Load: mem_read_i=1 -> dm_mem_read_o=1, dm_addr_o=addr_i; no drain that cycle.
REQ-009 Forwarding: addr_i[31:2] SHALL be compared against all valid entries; on match, the youngest matching entry's data is captured in the load cycle.
REQ-010 Load latency SHALL be exactly 1 cycle: the cycle after a load, data_valid_o=1 and data_o = forwarded data on hit, else dm_data_i; data_o holds until the next load completes.
REQ-011 mem_write_i=1 and mem_read_i=1 together SHALL be treated as a store only; load ignored, no data_valid_o pulse.
REQ-012 A store accepted in cycle N SHALL be visible to a load in cycle N+1 via forwarding.
REQ-013 empty_o = (count==0), registered-state-derived, no dependency on inputs.
REQ-014 Memory writes SHALL leave in program order; no coalescing of entries.

Reset
REQ-015 rst_i=0 at an edge -> count=0, head=tail=0, all pending stores discarded, data_o=0, data_valid_o=0; stall_o, dm_mem_write_o, dm_mem_read_o =0 while rst_i=0.
REQ-016 Reset mid-drain or mid-load SHALL abort the operation; no data_valid_o pulse for a load issued in the cycle reset is asserted.

Verification
REQ-017 Post-reset: stall_o=0, empty_o=1, data_o=0, data_valid_o=0, dm_mem_write_o=0.
REQ-018 Store 0x10=0xDEADBEEF then idle -> next cycle dm_mem_write_o=1, dm_addr_o=0x10, dm_data_o=0xDEADBEEF; following cycle empty_o=1.
REQ-019 Stores 0x20=0x1111, 0x20=0x2222, then load 0x20 -> one cycle later data_valid_o=1, data_o=0x2222; no memory write between them.
REQ-020 DEPTH=4: five back-to-back stores to 0x0,0x4,0x8,0xC,0x10 -> stall_o=1 for one cycle on the 5th, with drain of 0x0 that cycle; 5th accepted next cycle; later drains in order 0x4,0x8,0xC,0x10.
REQ-021 Memory holds 0xABCD at 0x40, buffer empty; load 0x40 -> dm_mem_read_o=1, dm_addr_o=0x40; next cycle data_o=0xABCD, data_valid_o=1.
REQ-022 Three pending stores, rst_i=0 for one cycle -> empty_o=1 afterward; no dm_mem_write_o pulse follows.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer between the CPU and data memory. Pending stores sit in a circular
// FIFO, drain to memory in program order on idle cycles, and forward to loads.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_write_i,
  input  logic        mem_read_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        stall_o,
  output logic [31:0] data_o,
  output logic        data_valid_o,
  output logic        empty_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_data_o,
  output logic        dm_mem_write_o,
  output logic        dm_mem_read_o,
  input  logic [31:0] dm_data_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  logic          load_q;
  logic          fwd_hit_q;
  logic [31:0]   fwd_data_q;
  logic [31:0]   data_hold_q;

  logic          full;
  logic          accept;
  logic          load;
  logic          drain;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [PW-1:0] idx;

  assign full    = (count_q == CW'(DEPTH));
  assign accept  = rst_i & mem_write_i & ~full;
  // A simultaneous read and write is a plain store; the load is dropped.
  assign load    = rst_i & mem_read_i & ~mem_write_i;
  assign drain   = rst_i & (count_q != '0) &
                   ((~mem_write_i & ~mem_read_i) | (mem_write_i & full));

  assign stall_o        = rst_i & mem_write_i & full;
  assign empty_o        = (count_q == '0);
  assign dm_mem_write_o = drain;
  assign dm_mem_read_o  = load;
  assign dm_addr_o      = load ? addr_i : addr_q[head_q];
  assign dm_data_o      = data_q[head_q];

  assign data_valid_o   = rst_i & load_q;
  assign data_o         = load_q ? (fwd_hit_q ? fwd_data_q : dm_data_i) : data_hold_q;

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((CW'(k) < count_q) && (addr_q[idx][31:2] == addr_i[31:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      load_q      <= 1'b0;
      fwd_hit_q   <= 1'b0;
      fwd_data_q  <= '0;
      data_hold_q <= '0;
    end else begin
      if (accept) tail_q <= tail_q + PW'(1);
      if (drain)  head_q <= head_q + PW'(1);
      count_q    <= count_q + CW'(accept) - CW'(drain);
      load_q     <= load;
      fwd_hit_q  <= fwd_hit;
      fwd_data_q <= fwd_data;
      if (load_q) data_hold_q <= data_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_q[tail_q] <= addr_i;
      data_q[tail_q] <= data_i;
    end
  end

endmodule
